// File: rtl/strobe_cmd_pkg.sv
// Shared constants for the strobe command queue and the register block that reads it back.
package strobe_cmd_pkg;

  localparam int unsigned DefDataWidth = 1;
  localparam int unsigned DefDepth     = 4;

  // Occupancy must represent 0..depth inclusive, hence one extra bit over the pointer.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/strobe_cmd_queue.sv
// Queues single-cycle register write strobes as commands and presents them first-word-fall-through
// over valid/ready, with occupancy readback and a sticky drop flag.
module strobe_cmd_queue
  import strobe_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth,
  localparam int unsigned PtrW      = $clog2(DEPTH),
  localparam int unsigned CntW      = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  cmd_valid_o,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  input  logic                  cmd_ready_i,
  output logic [CntW-1:0]       count_o,
  output logic                  full_o,
  output logic                  overflow_o,
  input  logic                  ovf_clr_i
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic empty, full, push, pop, drop;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CntW'(DEPTH));
    // A pop frees the slot a same-cycle push needs, so a full queue still accepts.
    pop   = !empty && cmd_ready_i;
    push  = wr_i && (!full || pop);
    drop  = wr_i && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Drop takes priority so software cannot lose a same-cycle overflow by clearing.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dat_i;
    end
  end

  assign cmd_valid_o = !empty;
  assign cmd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = full;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_strobe_cmd_queue.sv
// Self-checking bench for strobe_cmd_queue: hand-written vector table plus a data scoreboard.
module tb_strobe_cmd_queue;

  localparam int unsigned DW    = 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          wr_i;
  logic [DW-1:0] dat_i;
  logic          cmd_valid_o;
  logic [DW-1:0] cmd_data_o;
  logic          cmd_ready_i;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          overflow_o;
  logic          ovf_clr_i;

  strobe_cmd_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wr_i        (wr_i),
    .dat_i       (dat_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_ready_i (cmd_ready_i),
    .count_o     (count_o),
    .full_o      (full_o),
    .overflow_o  (overflow_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          wr;
    logic [DW-1:0] dat;
    logic          rdy;
    logic          clr;
    logic          e_valid;
    logic [DW-1:0] e_data;
    int            e_count;
    logic          e_full;
    logic          e_ovf;
  } vec_t;

  vec_t          tbl[13];
  logic [DW-1:0] sbq[$];
  logic          m_ovf;
  int            checks;
  int            errors;
  int            n_pops;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, int'(count_o), sbq.size());
    chk({tag, "_full"}, int'(full_o), int'(sbq.size() == DEPTH));
    chk({tag, "_valid"}, int'(cmd_valid_o), int'(sbq.size() != 0));
    chk({tag, "_data"}, int'(cmd_data_o), (sbq.size() != 0) ? int'(sbq[0]) : 0);
    chk({tag, "_ovf"}, int'(overflow_o), int'(m_ovf));
  endtask

  // Called at a falling edge: scores any pop, updates the model, drives one cycle, checks state.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rdy, input logic clr,
                      input string tag);
    bit pop;
    bit push;
    pop = (sbq.size() != 0) && rdy;
    if (pop) begin
      chk({tag, "_pop_valid"}, int'(cmd_valid_o), 1);
      chk({tag, "_pop_data"}, int'(cmd_data_o), int'(sbq[0]));
      void'(sbq.pop_front());
      n_pops++;
    end
    push = wr && (sbq.size() < DEPTH);
    if (push) sbq.push_back(d);
    if (wr && !push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    wr_i        = wr;
    dat_i       = d;
    cmd_ready_i = rdy;
    ovf_clr_i   = clr;
    @(negedge clk_i);
    wr_i        = 1'b0;
    dat_i       = '0;
    cmd_ready_i = 1'b0;
    ovf_clr_i   = 1'b0;
    chk_model(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_pops = 0;
    m_ovf  = 1'b0;

    //            wr    dat   rdy   clr   valid data  cnt full  ovf
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b1};  // dropped
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b1, 1'b0};  // clear alone
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0};  // push+pop when full
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1};  // drop wins over clear
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

    rst_n_i     = 1'b0;
    wr_i        = 1'b0;
    dat_i       = '0;
    cmd_ready_i = 1'b0;
    ovf_clr_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    chk_model("reset");

    // Single push: one-cycle latency, then a single pop.
    step(1'b1, 1'b1, 1'b0, 1'b0, "single_push");
    step(1'b0, 1'b0, 1'b1, 1'b0, "single_pop");

    // Fill, overflow, simultaneous events and drain.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].wr, tbl[i].dat, tbl[i].rdy, tbl[i].clr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_valid", i), int'(cmd_valid_o), int'(tbl[i].e_valid));
      chk($sformatf("vec%0d_tbl_data", i), int'(cmd_data_o), int'(tbl[i].e_data));
      chk($sformatf("vec%0d_tbl_count", i), int'(count_o), tbl[i].e_count);
      chk($sformatf("vec%0d_tbl_full", i), int'(full_o), int'(tbl[i].e_full));
      chk($sformatf("vec%0d_tbl_ovf", i), int'(overflow_o), int'(tbl[i].e_ovf));
    end

    // dat_i with wr_i low must not create an entry.
    step(1'b0, 1'b1, 1'b1, 1'b0, "idle_dat");

    // Wrap-around with ready held high: at most one entry in flight.
    n_pops = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(i % 2), 1'b1, 1'b0, $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d_cnt_le1", i), int'(count_o <= 1), 1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, "wrap_tail");
    chk("wrap_pop_total", n_pops, 10);

    // Asynchronous reset mid-operation.
    step(1'b1, 1'b1, 1'b0, 1'b0, "pre_rst0");
    step(1'b1, 1'b0, 1'b0, 1'b0, "pre_rst1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "pre_rst2");
    #2;
    rst_n_i = 1'b0;
    #1;
    sbq.delete();
    m_ovf = 1'b0;
    chk_model("async_rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, "post_rst0");
    step(1'b0, 1'b0, 1'b1, 1'b0, "post_rst1");
    step(1'b1, 1'b0, 1'b0, 1'b0, "post_rst_push");
    step(1'b0, 1'b0, 1'b1, 1'b0, "post_rst_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
